uart_receiver: RTL

Serial-to-parallel UART receiver: the receive end of the 8N1 link used by the host-facing UART. It recovers one byte per frame from the asynchronous serial line and presents it to the command/data path with a single-cycle valid strobe. It synchronises the line, rejects start-bit glitches, flags framing errors, and recovers from a held-low (break) line.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_receiver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding, default bit period and data width.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 607;
  localparam int unsigned DATA_W           = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    CLEANUP    = 3'd5,
    BREAK_WAIT = 3'd6
  } uart_state_e;

  // Even parity bit for a data word: 1 when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input. Both stages reset to 1 so an idle-high
// line never looks like activity right after reset.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_d, sync_q;

  // Shift the raw input through the two stages.
  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  // Synchroniser flops, preset to the line idle level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 by default. Define UART_RX_PARITY_EN to build an 8E1 receiver with a
// parity check and a driven o_RX_Parity_Err.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              i_Clock,
  input  logic              i_Rst,
  input  logic              i_RX_Serial,
  output logic [DATA_W-1:0] o_RX_Byte,
  output logic              o_RX_Valid,
  output logic              o_RX_Active,
  output logic              o_RX_Frame_Err,
  output logic              o_RX_Parity_Err
);

  localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned    IdxW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] HalfCnt = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk_i  (i_Clock),
    .rst_ni (i_Rst),
    .d_i    (i_RX_Serial),
    .q_o    (rx_s)
  );

  uart_state_e       state_d, state_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic [IdxW-1:0]   idx_d, idx_q;
  logic [DATA_W-1:0] shift_d, shift_q;
  logic [DATA_W-1:0] byte_d, byte_q;
  logic              active_d, active_q;
  logic              valid_d, valid_q;
  logic              ferr_d, ferr_q;
  logic              par_err;

`ifdef UART_RX_PARITY_EN
  logic perr_d, perr_q;
  logic par_bit_d, par_bit_q;
  assign par_err = (par_bit_q != even_parity(shift_q));
`else
  assign par_err = 1'b0;
`endif

  // Next-state logic: bit timing, sampling, and frame outcome strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    active_d = active_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bit_d = par_bit_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HalfCnt) begin
          cnt_d = '0;
          // A start bit that is gone by mid-bit is a glitch.
          if (!rx_s) begin
            active_d = 1'b1;
            state_d  = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FullCnt) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LastIdx) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FullCnt) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FullCnt) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (!rx_s) begin
            // Low stop bit: report once, then wait out any break.
            ferr_d  = 1'b1;
            state_d = BREAK_WAIT;
          end else if (par_err) begin
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b1;
`endif
            state_d = CLEANUP;
          end else begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = CLEANUP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEANUP: begin
        state_d = IDLE;
      end
      BREAK_WAIT: begin
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_Clock or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity sample and error strobe.
  always_ff @(posedge i_Clock or negedge i_Rst) begin
    if (!i_Rst) begin
      perr_q    <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      perr_q    <= perr_d;
      par_bit_q <= par_bit_d;
    end
  end
  assign o_RX_Parity_Err = perr_q;
`else
  assign o_RX_Parity_Err = 1'b0;
`endif

  assign o_RX_Byte      = byte_q;
  assign o_RX_Valid     = valid_q;
  assign o_RX_Active    = active_q;
  assign o_RX_Frame_Err = ferr_q;

endmodule
